// File: rtl/digit_buffer_if.sv
// Write/replay bus of the digit buffer: counter-side digit writes in, valid/ready digit stream out.
// master drives the write and request side; slave is the buffer itself.
interface digit_buffer_if #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DIGIT_W = 2
);
  logic               enable;
  logic               write_enable;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DIGIT_W-1:0] wr_digit;
  logic               rd_start;
  logic [ADDR_W:0]    rd_len;
  logic               out_valid;
  logic               out_ready;
  logic [DIGIT_W-1:0] out_digit;
  logic               out_last;
  logic               busy;
  logic [ADDR_W:0]    fill;
  logic               rd_err;
  logic               bad_digit;

  modport master (
    output enable, write_enable, wr_addr, wr_digit, rd_start, rd_len, out_ready,
    input  out_valid, out_digit, out_last, busy, fill, rd_err, bad_digit
  );

  modport slave (
    input  enable, write_enable, wr_addr, wr_digit, rd_start, rd_len, out_ready,
    output out_valid, out_digit, out_last, busy, fill, rd_err, bad_digit
  );
endinterface

// File: rtl/digit_buffer.sv
// Stores signed result digits at counter-supplied addresses and replays a prefix of them,
// address 0 first, over a valid/ready stream (one digit every two cycles).
module digit_buffer #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned DIGIT_W = 2
) (
  input logic           clk,
  input logic           rst,
  digit_buffer_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StFetch, StPresent} state_e;

  localparam logic [ADDR_W:0] LenOne = (ADDR_W + 1)'(1);

  logic [DIGIT_W-1:0] mem_q [DEPTH];

  state_e             state_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [ADDR_W:0]    len_q;
  logic               out_valid_q;
  logic [DIGIT_W-1:0] out_digit_q;
  logic               out_last_q;
  logic               rd_err_q;
  logic [ADDR_W:0]    fill_q, fill_d;
  logic               bad_q;

  logic               wr_en;
  logic               wr_illegal;
  logic [DIGIT_W-1:0] wr_data;
  logic [ADDR_W:0]    wr_next;
  logic               len_ok;

  assign wr_en      = bus.enable && bus.write_enable;
  assign wr_illegal = &bus.wr_digit;
  assign wr_data    = wr_illegal ? '0 : bus.wr_digit;
  assign wr_next    = {1'b0, bus.wr_addr} + LenOne;
  assign len_ok     = (bus.rd_len != '0) && (bus.rd_len <= fill_q);

  // wr_next never exceeds DEPTH, so the max alone saturates fill and survives counter wrap.
  always_comb begin
    fill_d = fill_q;
    if (wr_en && (wr_next > fill_q)) begin
      fill_d = wr_next;
    end
  end

  // Storage is never cleared; fill gates what may be read back.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[bus.wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_digit_q <= '0;
      out_last_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      fill_q      <= '0;
      bad_q       <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      bad_q    <= bad_q | (wr_en & wr_illegal);
      rd_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.rd_start) begin
            if (len_ok) begin
              len_q     <= bus.rd_len;
              rd_addr_q <= '0;
              state_q   <= StFetch;
            end else begin
              rd_err_q <= 1'b1;
            end
          end
        end
        // Reading here, before any same-edge write lands, gives read-before-write.
        StFetch: begin
          out_digit_q <= mem_q[rd_addr_q];
          out_valid_q <= 1'b1;
          out_last_q  <= ({1'b0, rd_addr_q} == (len_q - LenOne));
          state_q     <= StPresent;
        end
        StPresent: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              out_last_q <= 1'b0;
              state_q    <= StIdle;
            end else begin
              rd_addr_q <= rd_addr_q + ADDR_W'(1);
              state_q   <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_digit = out_digit_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.fill      = fill_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.bad_digit = bad_q;
endmodule

// File: doc/digit_buffer.md
Name: digit_buffer

Overview:
- Downstream consumer of the address counter in the online multiplier datapath.
- Captures each result digit, most-significant first, at the address the counter supplies, using the same enable/write_enable qualification.
- On request, replays a stored prefix of digits in address order through a valid/ready stream to the next stage (serializer/result formatter).
- Tracks fill level and flags malformed digits and bad read requests.

Parameters:
- ADDR_W, 9, address width; matches the 9-bit counter output.
- DEPTH, 512, number of digit slots (2**ADDR_W).
- DIGIT_W, 2, signed-digit encoding width: {plus,minus}; 00=0, 10=+1, 01=-1, 11=illegal.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  stage enable (same qualifier the counter uses)
- write_enable  in  1  digit write strobe; a write occurs only when enable&&write_enable
- wr_addr  in  ADDR_W  write address, driven by counter cnt
- wr_digit  in  DIGIT_W  digit to store
- rd_start  in  1  single-cycle request to replay digits 0..rd_len-1
- rd_len  in  ADDR_W+1  number of digits to replay (1..DEPTH)
- out_valid  out  1  out_digit/out_last valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_digit  out  DIGIT_W  replayed digit
- out_last  out  1  high with the final digit of a replay
- busy  out  1  replay in progress (state != IDLE)
- fill  out  ADDR_W+1  highest written address + 1, saturating at DEPTH
- rd_err  out  1  one-cycle pulse: request rejected
- bad_digit  out  1  sticky: an illegal digit (11) was written

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_digit=0, out_last=0, busy=0, fill=0, rd_err=0, bad_digit=0, state=IDLE, rd_addr=0. Memory contents are not cleared; fill=0 prevents reading them.
- Write path:
  - Every cycle with enable&&write_enable, mem[wr_addr] <= wr_digit at the clock edge.
  - An illegal 11 digit is stored as 00 and sets bad_digit, which clears only on rst.
  - fill <= max(fill, wr_addr+1), held at DEPTH once reached. When the counter wraps 511->0, fill stays 512.
  - Writes are accepted in every state, including during a replay.
- Read FSM states: IDLE, FETCH, PRESENT.
  - IDLE:
    - rd_start with 1<=rd_len<=fill: latch len, rd_addr<=0, go to FETCH.
    - rd_start with rd_len==0 or rd_len>fill: rd_err=1 for one cycle, stay IDLE.
  - FETCH: synchronous memory read of mem[rd_addr]. Next cycle, register the data onto out_digit, set out_valid=1, set out_last=(rd_addr==len-1), go to PRESENT.
  - PRESENT:
    - Hold out_digit/out_last stable while out_valid&&!out_ready.
    - On accept with !out_last: out_valid<=0, rd_addr++, go to FETCH.
    - On accept with out_last: out_valid<=0, out_last<=0, go to IDLE.
- Timing:
  - First out_valid occurs 2 cycles after the rd_start cycle.
  - Throughput is 1 digit per 2 cycles with out_ready held high.
- rd_start while busy is ignored: no error, no restart.
- Same-address write and FETCH read in one cycle: read returns the old value (read-before-write).
- rst mid-replay: immediate abort, out_valid drops asynchronously, no out_last is produced.
- All address arithmetic is unsigned. rd_addr never exceeds len-1, so there is no read wrap-around.

Test Plan:
- Write digits +1,-1,0,+1 at addr 0..3 (enable=write_enable=1), then rd_start rd_len=4 with out_ready=1 -> out_digit sequence 10,01,00,10; out_last only on the 4th; fill=4; first out_valid 2 cycles after rd_start.
- Same fill, rd_len=3, out_ready low for 5 cycles on the 2nd digit -> out_digit=01 held stable with out_valid=1 for all 5 cycles; no digit skipped or duplicated; busy drops after the 3rd accept.
- fill=4, rd_start rd_len=5 -> rd_err pulses 1 cycle, busy stays 0. rd_len=0 -> same. rd_start during a replay -> ignored, replay completes unchanged.
- Write wr_digit=11 at addr 7 -> bad_digit=1 and stays 1; a later replay of addr 7 yields 00; fill=8.
- Write all 512 addresses, then a further write at wr_addr=0 after wrap -> fill=512 (not 1); rd_len=512 replays all 512 digits and the new addr-0 value appears first.
- Assert rst during PRESENT of the 2nd digit -> out_valid, busy and fill go to 0 immediately; a subsequent rd_start rd_len=1 gives rd_err until new writes occur.
